// File: rtl/jk_bank_arbiter_if.sv
// Command/status bundle between two JK command sources and the bank arbiter.
// The master side issues req/op/idx; the slave side returns acks and bank state.
interface jk_bank_arbiter_if #(
  parameter int N    = 8,
  parameter int IDXW = 3
);
  logic            req0;
  logic [1:0]      op0;
  logic [IDXW-1:0] idx0;
  logic            ack0;
  logic            req1;
  logic [1:0]      op1;
  logic [IDXW-1:0] idx1;
  logic            ack1;
  logic [N-1:0]    q;
  logic [N-1:0]    qnot;
  logic            busy;
  logic            err;
  logic            last_grant;

  modport master (
    output req0, op0, idx0, req1, op1, idx1,
    input  ack0, ack1, q, qnot, busy, err, last_grant
  );

  modport slave (
    input  req0, op0, idx0, req1, op1, idx1,
    output ack0, ack1, q, qnot, busy, err, last_grant
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of N JK cells between two requesters.
// IDLE samples requests, GRANT acks the winner, APPLY drives j/k into one cell.
module jk_bank_arbiter #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic         clk,
  input  logic         reset,
  jk_bank_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, APPLY = 2'd2} state_t;

  localparam logic [IDXW:0] NLIM = (IDXW+1)'(N);

  state_t          state, state_next;
  logic            take, winner, oor;
  logic            last_grant, ack0, ack1, err;
  logic [1:0]      op_sel, op_l;
  logic [IDXW-1:0] idx_sel, idx_l;
  logic [N-1:0]    q, q_next, j, k;

  always_comb begin
    state_next = state;
    take       = (state == IDLE) && (bus.req0 || bus.req1);
    // Contested: favour whoever did not win last; otherwise the lone requester.
    winner     = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    op_sel     = winner ? bus.op1  : bus.op0;
    idx_sel    = winner ? bus.idx1 : bus.idx0;
    oor        = {1'b0, idx_sel} >= NLIM;
    case (state)
      IDLE:    if (take) state_next = GRANT;
      GRANT:   state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the addressed cell sees the latched op; an out-of-range index matches none.
  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (state == APPLY && idx_l == IDXW'(i)) begin
        j[i] = op_l[1];
        k[i] = op_l[0];
      end
    end
    q_next = (j & ~q) | (~k & q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err        <= 1'b0;
      q          <= '0;
    end else begin
      state <= state_next;
      ack0  <= take & ~winner;
      ack1  <= take & winner;
      err   <= take & oor;
      q     <= q_next;
      if (take) last_grant <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      op_l  <= op_sel;
      idx_l <= idx_sel;
    end
  end

  assign bus.ack0       = ack0;
  assign bus.ack1       = ack1;
  assign bus.err        = err;
  assign bus.last_grant = last_grant;
  assign bus.q          = q;
  assign bus.qnot       = ~q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: an N=8 bank for the main flow and an
// N=6 bank for out-of-range indices.
module tb_jk_bank_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.N(8), .IDXW(3)) i8 ();
  jk_bank_arbiter_if #(.N(6), .IDXW(3)) i6 ();

  jk_bank_arbiter #(.N(8), .IDXW(3)) u8 (.clk(clk), .reset(reset), .bus(i8.slave));
  jk_bank_arbiter #(.N(6), .IDXW(3)) u6 (.clk(clk), .reset(reset), .bus(i6.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One requester-1 command on the 8-cell bank, with handshake timing checks.
  task automatic cmd1(input logic [1:0] op, input logic [2:0] idx,
                      input logic [7:0] exp_q, input string tag);
    i8.req1 = 1'b1; i8.op1 = op; i8.idx1 = idx;
    step();
    check({tag, "_ack1"}, i8.ack1, 1);
    check({tag, "_ack0"}, i8.ack0, 0);
    i8.req1 = 1'b0;
    step();
    check({tag, "_ack1_drop"}, i8.ack1, 0);
    step();
    check({tag, "_q"}, i8.q, exp_q);
    check({tag, "_busy"}, i8.busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i8.req0 = 1'b1; i8.op0 = 2'b10; i8.idx0 = 3'd3;
    i8.req1 = 1'b0; i8.op1 = 2'b00; i8.idx1 = 3'd0;
    i6.req0 = 1'b0; i6.op0 = 2'b00; i6.idx0 = 3'd0;
    i6.req1 = 1'b0; i6.op1 = 2'b00; i6.idx1 = 3'd0;

    // Reset held with a pending request
    repeat (3) step();
    check("rst_q", i8.q, 8'h00);
    check("rst_qnot", i8.qnot, 8'hFF);
    check("rst_ack0", i8.ack0, 0);
    check("rst_ack1", i8.ack1, 0);
    check("rst_busy", i8.busy, 0);
    check("rst_lg", i8.last_grant, 1);
    check("rst_err", i8.err, 0);

    // Single set of bit 3 by requester 0
    reset = 1'b1;
    step();
    check("s_ack0", i8.ack0, 1);
    check("s_busy0", i8.busy, 1);
    check("s_q0", i8.q, 8'h00);
    check("s_lg", i8.last_grant, 0);
    i8.req0 = 1'b0;
    step();
    check("s_ack0_drop", i8.ack0, 0);
    check("s_busy1", i8.busy, 1);
    check("s_q1", i8.q, 8'h00);
    step();
    check("s_q2", i8.q, 8'h08);
    check("s_qnot2", i8.qnot, 8'hF7);
    check("s_busy2", i8.busy, 0);

    // Toggle, toggle, hold, clear via requester 1
    cmd1(2'b11, 3'd3, 8'h00, "tog_a");
    cmd1(2'b11, 3'd3, 8'h08, "tog_b");
    cmd1(2'b00, 3'd3, 8'h08, "hold");
    cmd1(2'b01, 3'd3, 8'h00, "clr");
    check("pre_rr_lg", i8.last_grant, 1);

    // Round-robin under continuous contention
    i8.req0 = 1'b1; i8.op0 = 2'b10; i8.idx0 = 3'd0;
    i8.req1 = 1'b1; i8.op1 = 2'b10; i8.idx1 = 3'd7;
    for (int c = 0; c < 12; c++) begin
      step();
      check($sformatf("rr_ack0_%0d", c), i8.ack0, ((c % 3 == 0) && ((c / 3) % 2 == 0)) ? 1 : 0);
      check($sformatf("rr_ack1_%0d", c), i8.ack1, ((c % 3 == 0) && ((c / 3) % 2 == 1)) ? 1 : 0);
      if (c == 2) check("rr_q_first", i8.q, 8'h01);
      if (c == 5) check("rr_q_second", i8.q, 8'h81);
      if (c == 9) begin
        i8.req0 = 1'b0;
        i8.req1 = 1'b0;
      end
    end
    check("rr_busy_end", i8.busy, 0);
    check("rr_lg_end", i8.last_grant, 1);

    // Out-of-range on the 6-cell bank, then an in-range set of bit 5
    i6.req0 = 1'b1; i6.op0 = 2'b10; i6.idx0 = 3'd7;
    step();
    check("oor_ack0", i6.ack0, 1);
    check("oor_err", i6.err, 1);
    i6.req0 = 1'b0;
    step();
    check("oor_err_drop", i6.err, 0);
    step();
    check("oor_q", i6.q, 6'h00);
    i6.req0 = 1'b1; i6.op0 = 2'b10; i6.idx0 = 3'd5;
    step();
    check("inr_ack0", i6.ack0, 1);
    check("inr_err", i6.err, 0);
    i6.req0 = 1'b0;
    step();
    step();
    check("inr_q", i6.q, 6'h20);

    // Reset during APPLY of a set on bit 5
    i8.req0 = 1'b1; i8.op0 = 2'b10; i8.idx0 = 3'd5;
    step();
    check("mid_ack0", i8.ack0, 1);
    i8.req0 = 1'b0;
    step();
    check("mid_busy_apply", i8.busy, 1);
    reset = 1'b0;
    #1;
    check("mid_q", i8.q, 8'h00);
    check("mid_busy", i8.busy, 0);
    check("mid_lg", i8.last_grant, 1);
    check("mid_ack0_clr", i8.ack0, 0);
    step();
    step();
    reset = 1'b1;
    step();
    check("mid_q_after", i8.q, 8'h00);
    check("mid_busy_after", i8.busy, 0);
    cmd1(2'b10, 3'd2, 8'h04, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
